// File: rtl/sha_msg_schedule.sv
// SHA-2 message-schedule expander.
// Takes the 16 words of one padded block and streams out W[0..ROUNDS-1]
// over valid/ready, expanding W[16..] on the fly from a 16-word window.
module sha_msg_schedule #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [6:0]        out_index,
    output logic              busy,
    output logic              done
);

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_width
        $error("sha_msg_schedule: WORD_W must be 32 or 64");
    end

    localparam int         ROUNDS = (WORD_W == 64) ? 80 : 64;
    localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);
    localparam logic [6:0] T_LOAD = 7'd15;

    // SHA-256 vs SHA-512 rotate/shift amounts
    localparam int S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int S1_SH = (WORD_W == 64) ? 6  : 10;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DRAIN} state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    state_t            r_state, w_next;
    logic [6:0]        r_t;
    logic [WORD_W-1:0] r_buf [16];
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_word;
    logic [6:0]        r_out_index;

    logic              w_adv, w_in_ready, w_done;
    logic              w_take_in, w_take_exp, w_drop, w_t_clr;
    logic [WORD_W-1:0] w_s0, w_s1, w_new, w_src;

    // Output register is a single stage: it may be refilled whenever it is
    // empty or being consumed this cycle.
    assign w_adv = !r_out_valid || out_ready;

    // Expansion from the window: buf[15]=W[t-1] ... buf[0]=W[t-16]
    assign w_s0  = rotr(r_buf[1], S0_R1) ^ rotr(r_buf[1], S0_R2) ^ (r_buf[1] >> S0_SH);
    assign w_s1  = rotr(r_buf[14], S1_R1) ^ rotr(r_buf[14], S1_R2) ^ (r_buf[14] >> S1_SH);
    assign w_new = w_s1 + r_buf[9] + w_s0 + r_buf[0];
    assign w_src = w_take_exp ? w_new : in_word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and per-cycle control; abort overrides everything
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_done     = 1'b0;
        w_take_in  = 1'b0;
        w_take_exp = 1'b0;
        w_drop     = 1'b0;
        w_t_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_LOAD;
                    w_t_clr = 1'b1;
                end
            end
            S_LOAD: begin
                w_in_ready = w_adv;
                if (in_valid && w_adv) begin
                    w_take_in = 1'b1;
                    if (r_t == T_LOAD) w_next = S_EXPAND;
                end else if (out_ready) begin
                    w_drop = 1'b1;
                end
            end
            S_EXPAND: begin
                if (w_adv) begin
                    w_take_exp = 1'b1;
                    if (r_t == T_LAST) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    w_done = 1'b1;
                    w_drop = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next     = S_IDLE;
            w_in_ready = 1'b0;
            w_done     = 1'b0;
            w_take_in  = 1'b0;
            w_take_exp = 1'b0;
            w_drop     = 1'b0;
            w_t_clr    = 1'b0;
        end
    end

    // Datapath: output register, window shift and round counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_index <= '0;
            r_t         <= '0;
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
        end else if (abort) begin
            r_out_valid <= 1'b0;
        end else if (w_take_in || w_take_exp) begin
            r_out_valid <= 1'b1;
            r_out_word  <= w_src;
            r_out_index <= r_t;
            for (int i = 0; i < 15; i++) r_buf[i] <= r_buf[i+1];
            r_buf[15]   <= w_src;
            // counter parks on the last round instead of running past it
            if (!(w_take_exp && r_t == T_LAST)) r_t <= r_t + 7'd1;
        end else begin
            if (w_drop)  r_out_valid <= 1'b0;
            if (w_t_clr) r_t <= '0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_index = r_out_index;
    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: SHA-256 and SHA-512 instances, "abc" block,
// scoreboard queue filled at block start, popped by a negedge monitor.
module tb_sha_msg_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, abort, in_valid, out_ready, start32, start64;
    logic [31:0] in_word32;
    logic [63:0] in_word64;

    logic        in_ready32, out_valid32, busy32, done32;
    logic [31:0] out_word32;
    logic [6:0]  out_index32;
    logic        in_ready64, out_valid64, busy64, done64;
    logic [63:0] out_word64;
    logic [6:0]  out_index64;

    sha_msg_schedule #(.WORD_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready32), .in_word(in_word32),
        .out_valid(out_valid32), .out_ready(out_ready), .out_word(out_word32),
        .out_index(out_index32), .busy(busy32), .done(done32)
    );

    sha_msg_schedule #(.WORD_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready64), .in_word(in_word64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_word(out_word64),
        .out_index(out_index64), .busy(busy64), .done(done64)
    );

    // currently exercised instance
    logic        sel;
    logic        c_in_ready, c_out_valid, c_busy, c_done;
    logic [63:0] c_out_word;
    logic [6:0]  c_out_index;
    assign c_in_ready  = sel ? in_ready64  : in_ready32;
    assign c_out_valid = sel ? out_valid64 : out_valid32;
    assign c_busy      = sel ? busy64      : busy32;
    assign c_done      = sel ? done64      : done32;
    assign c_out_word  = sel ? out_word64  : {32'b0, out_word32};
    assign c_out_index = sel ? out_index64 : out_index32;

    typedef struct {int idx; logic [63:0] w;} exp_t;
    exp_t        q[$];
    logic [63:0] sched [80];
    int          errs = 0, checks = 0, done_cnt = 0;

    // stimulus-side controls
    int rmode = 0, stall_cnt = 0, abort_at = -1, start_at = -1;
    bit st15 = 0, st16 = 0, abort_pend = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input bit w64);
        logic [127:0] d;
        if (w64) begin
            d = {x, x} >> n;
            return d[63:0];
        end
        d = {64'b0, x[31:0], x[31:0]} >> n;
        return {32'b0, d[31:0]};
    endfunction

    function automatic logic [63:0] sg0(input logic [63:0] x, input bit w64);
        return w64 ? (rr(x, 1, 1) ^ rr(x, 8, 1) ^ (x >> 7))
                   : (rr(x, 7, 0) ^ rr(x, 18, 0) ^ (x >> 3));
    endfunction

    function automatic logic [63:0] sg1(input logic [63:0] x, input bit w64);
        return w64 ? (rr(x, 19, 1) ^ rr(x, 61, 1) ^ (x >> 6))
                   : (rr(x, 17, 0) ^ rr(x, 19, 0) ^ (x >> 10));
    endfunction

    // "abc" block; first few expanded words are the hand-worked values
    task automatic build(input bit w64);
        int r;
        logic [63:0] s;
        r = w64 ? 80 : 64;
        for (int i = 0; i < 80; i++) sched[i] = '0;
        sched[0]  = w64 ? 64'h6162638000000000 : 64'h0000000061626380;
        sched[15] = 64'h18;
        for (int t = 16; t < r; t++) begin
            s = sg1(sched[t-2], w64) + sched[t-7] + sg0(sched[t-15], w64) + sched[t-16];
            sched[t] = w64 ? s : (s & 64'hFFFF_FFFF);
        end
        if (w64) begin
            sched[16] = 64'h6162638000000000;
            sched[17] = 64'h00030000000000C0;
        end else begin
            sched[16] = 64'h61626380;
            sched[17] = 64'h000F0000;
            sched[18] = 64'h7DA86405;
        end
        for (int t = 0; t < r; t++) q.push_back('{t, sched[t]});
    endtask

    // out_ready pattern, abort/start injection; runs just after each posedge
    task automatic ready_gen();
        start32 = 1'b0;
        start64 = 1'b0;
        abort   = 1'b0;
        if (abort_pend) begin
            chk("abort_out_valid", 64'(c_out_valid), 64'd0);
            chk("abort_busy", 64'(c_busy), 64'd0);
            q.delete();
            abort_pend = 0;
        end
        if (abort_at >= 0 && c_out_valid && int'(c_out_index) == abort_at) begin
            abort = 1'b1;
            out_ready = 1'b0;
            abort_at = -1;
            abort_pend = 1;
            return;
        end
        if (start_at >= 0 && c_out_valid && int'(c_out_index) == start_at) begin
            if (sel) start64 = 1'b1; else start32 = 1'b1;
            start_at = -1;
        end
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rmode == 1 && c_out_valid && c_out_index == 7'd15 && !st15) begin
            st15 = 1; stall_cnt = 4; out_ready = 1'b0;
        end else if (rmode == 1 && c_out_valid && c_out_index == 7'd16 && !st16) begin
            st16 = 1; stall_cnt = 4; out_ready = 1'b0;
        end else begin
            out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        ready_gen();
    endtask

    task automatic run_block(input bit s, input int mode, input int ab_at,
                             input int st_at, input int rst_at);
        int k, n, d0;
        sel = s; rmode = mode; st15 = 0; st16 = 0; stall_cnt = 0;
        abort_at = ab_at; start_at = st_at;
        build(s);
        d0 = done_cnt;
        cyc();
        if (s) start64 = 1'b1; else start32 = 1'b1;
        cyc();
        k = 0; n = 0;
        while (k < 16 && n < 500) begin
            if (rst_at >= 0 && k == rst_at) begin
                #2 rst_n = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("rst_out_valid", 64'(c_out_valid), 64'd0);
                chk("rst_out_word", c_out_word, 64'd0);
                chk("rst_out_index", 64'(c_out_index), 64'd0);
                chk("rst_busy", 64'(c_busy), 64'd0);
                chk("rst_in_ready", 64'(c_in_ready), 64'd0);
                q.delete();
                repeat (2) @(posedge clk);
                #3 rst_n = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    cyc();
                    chk("post_rst_in_ready", 64'(c_in_ready), 64'd0);
                end
                chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
                return;
            end
            in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_word32 = sched[k][31:0];
            in_word64 = sched[k];
            #1;
            if (in_valid && c_in_ready) k++;
            cyc();
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while (c_busy && n < 2000) begin
            cyc();
            n++;
        end
        chk("busy_timeout", 64'(c_busy), 64'd0);
        cyc();
        chk("done_pulses", 64'(done_cnt - d0), (ab_at >= 0) ? 64'd0 : 64'd1);
        chk("words_left", 64'(q.size()), 64'd0);
    endtask

    // monitor: pops the scoreboard on each output handshake
    bit          prev_stall = 0, prev_done = 0;
    logic [63:0] held_w;
    logic [6:0]  held_i;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || abort) begin
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            if (prev_done) chk("busy_after_done", 64'(c_busy), 64'd0);
            if (prev_stall && c_out_valid) begin
                chk("stall_word", c_out_word, held_w);
                chk("stall_index", 64'(c_out_index), 64'(held_i));
            end
            if (c_out_valid && out_ready) begin
                chk("expected_pending", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_index", 64'(c_out_index), 64'(e.idx));
                    chk("out_word", c_out_word, e.w);
                    chk("done_on_last", 64'(c_done), 64'(e.idx == (sel ? 79 : 63)));
                end
            end else if (c_done) begin
                chk("spurious_done", 64'(c_done), 64'd0);
            end
            prev_stall = c_out_valid && !out_ready;
            held_w     = c_out_word;
            held_i     = c_out_index;
            prev_done  = c_done;
            if (c_done) done_cnt++;
        end
    end

    initial begin
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        start32 = 1'b0; start64 = 1'b0; in_word32 = '0; in_word64 = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_out_valid32", 64'(out_valid32), 64'd0);
        chk("reset_in_ready32", 64'(in_ready32), 64'd0);
        chk("reset_busy32", 64'(busy32), 64'd0);
        chk("reset_done32", 64'(done32), 64'd0);
        chk("reset_out_word32", 64'(out_word32), 64'd0);
        chk("reset_out_index32", 64'(out_index32), 64'd0);
        chk("reset_out_valid64", 64'(out_valid64), 64'd0);
        chk("reset_out_word64", out_word64, 64'd0);
        chk("reset_busy64", 64'(busy64), 64'd0);
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("idle_in_ready", 64'(in_ready32), 64'd0);

        run_block(0, 0, -1, -1, -1);   // SHA-256 abc, free-flowing
        run_block(0, 1, -1, -1, -1);   // random backpressure + stalls at 15/16
        run_block(1, 0, -1, -1, -1);   // SHA-512 abc
        run_block(1, 1, -1, -1, -1);   // SHA-512 with backpressure
        run_block(0, 0, -1, 30, -1);   // start pulsed during expansion
        run_block(0, 0, 20, -1, -1);   // abort at t=20
        run_block(0, 0, -1, -1, -1);   // full block after abort
        run_block(0, 0, -1, -1, 7);    // async reset mid-load
        run_block(0, 1, -1, -1, -1);   // full block after reset

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
